// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single memory port.
// One access in flight at a time; alternating priority on simultaneous requests;
// a wait counter bounds each memory access and reports a timeout through err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  // Wide enough to hold TIMEOUT itself, so the post-increment never wraps.
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                state, nxt;
  owner_t                owner, prio, grant;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CW-1:0]         cnt;
  logic                  any_req;
  logic                  timeout_hit;

  assign any_req     = i_req | d_req;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Pick the winner: a lone requester wins, a tie goes to the prio holder.
  always_comb begin
    grant = OWN_I;
    if (i_req && d_req) grant = prio;
    else if (d_req)     grant = OWN_D;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; mem_resp only matters while in REQ, and beats the timeout.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (any_req) nxt = ST_REQ;
      ST_REQ: begin
        if (mem_resp)         nxt = we_q ? ST_DONE : ST_DATA;
        else if (timeout_hit) nxt = ST_ERR;
      end
      ST_DATA: nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      ST_ERR:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Access context: latched at grant, wait counter runs in REQ, read data lands in DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_I;
      prio    <= OWN_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (any_req) begin
          owner   <= grant;
          prio    <= (grant == OWN_I) ? OWN_D : OWN_I;
          addr_q  <= (grant == OWN_I) ? i_addr : d_addr;
          we_q    <= (grant == OWN_D) && d_we;
          wdata_q <= (grant == OWN_D) ? d_wdata : '0;
          rdata_q <= '0;
          cnt     <= '0;
        end
        ST_REQ:  cnt     <= cnt + 1'b1;
        ST_DATA: rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; strobes only in REQ, done/rdata only to the owner.
  always_comb begin
    mem_read  = (state == ST_REQ) && !we_q;
    mem_write = (state == ST_REQ) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    err       = (state == ST_ERR);
    i_done    = ((state == ST_DONE) || (state == ST_ERR)) && (owner == OWN_I);
    d_done    = ((state == ST_DONE) || (state == ST_ERR)) && (owner == OWN_D);
    i_rdata   = (state == ST_DONE && owner == OWN_I) ? rdata_q : '0;
    d_rdata   = (state == ST_DONE && owner == OWN_D) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, arbitration, timeout, reset abort, stray resp.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp;

  // memory model controls
  logic        mem_en = 1'b1;
  int          mem_delay = 2;
  logic [31:0] mem_data = '0;
  logic        resp_model = 1'b0;
  logic        stray = 1'b0;
  int          wcnt = 0;

  // monitor state
  int          low_run = 0, last_gap = 0, both_hi = 0, i_done_cnt = 0;
  logic        prev_act = 1'b0;
  logic [31:0] act_addr = '0, act_wdata = '0;

  int n_checks = 0, n_errs = 0;

  assign mem_resp = resp_model | stray;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory: respond on the mem_delay-th active cycle, data held through the next cycle.
  always @(negedge clk) begin
    if (mem_en && (mem_read || mem_write) && !resp_model) begin
      wcnt = wcnt + 1;
      if (wcnt == mem_delay) begin
        resp_model = 1'b1;
        mem_rdata  = mem_data;
      end
    end else begin
      resp_model = 1'b0;
      if (!(mem_read || mem_write)) wcnt = 0;
    end
  end

  // Bus monitor: idle gap before each access, captured address/data, protocol counters.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi++;
    if (i_done) i_done_cnt++;
    if (mem_read || mem_write) begin
      if (!prev_act) last_gap = low_run;
      low_run   = 0;
      act_addr  = mem_addr;
      act_wdata = mem_wdata;
    end else begin
      low_run++;
    end
    prev_act = mem_read || mem_write;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Wait for a done pulse; drops the finishing requester's req at once.
  task automatic wait_done(input string tag, input int budget, output int cyc,
                           output logic gi, output logic gd, output logic ge,
                           output logic [31:0] ri, output logic [31:0] rd,
                           output int nrd, output int nwr);
    cyc = 0; nrd = 0; nwr = 0;
    gi = 0; gd = 0; ge = 0; ri = '0; rd = '0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      if (i_done || d_done) begin
        gi = i_done; gd = d_done; ge = err; ri = i_rdata; rd = d_rdata;
        if (i_done) i_req = 1'b0;
        if (d_done) d_req = 1'b0;
        break;
      end
    end
    if (!(gi || gd)) chk({tag, "_done_seen"}, {31'b0, i_done | d_done}, 32'd1);
  endtask

  // The cycle after a done: no pulse, no data on either port.
  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, {29'b0, i_done, d_done, err}, 32'd0);
    chk({tag, "_rdata_zero"}, i_rdata | d_rdata, 32'd0);
  endtask

  int          cyc, nrd, nwr;
  logic        gi, gd, ge;
  logic [31:0] ri, rd;

  initial begin
    // Reset: requests during reset are not sampled, outputs all quiet.
    i_req = 1'b1; i_addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", {29'b0, i_done, d_done, err}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    i_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Instruction read, delay 2: mem_resp + DATA + DONE -> 4 cycles from raise.
    mem_data = 32'hDEADBEEF; i_addr = 32'h10; i_req = 1'b1;
    wait_done("i_rd", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("i_rd_lat", cyc, 32'd4);
    chk("i_rd_owner", {30'b0, gi, gd}, 32'b10);
    chk("i_rd_data", ri, 32'hDEADBEEF);
    chk("i_rd_nrd", nrd, 32'd2);
    chk("i_rd_nwr", nwr, 32'd0);
    chk("i_rd_addr", act_addr, 32'h10);
    after_done("i_rd");
    chk("i_rd_once", i_done_cnt, 32'd1);

    // Data write: REQ(2) + DONE -> 3 cycles; no read strobe; rdata 0.
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; d_req = 1'b1;
    wait_done("d_wr", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("d_wr_lat", cyc, 32'd3);
    chk("d_wr_owner", {30'b0, gi, gd}, 32'b01);
    chk("d_wr_nwr", nwr, 32'd2);
    chk("d_wr_nrd", nrd, 32'd0);
    chk("d_wr_addr", act_addr, 32'h20);
    chk("d_wr_wdata", act_wdata, 32'h12345678);
    chk("d_wr_rdata", rd, 32'd0);
    after_done("d_wr");

    // Simultaneous requests after reset: instruction first, then data.
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    d_we = 1'b0; d_addr = 32'h40; i_addr = 32'h30;
    mem_data = 32'hA5A50001;
    i_req = 1'b1; d_req = 1'b1;
    wait_done("both1", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("both1_owner", {30'b0, gi, gd}, 32'b10);
    chk("both1_data", ri, 32'hA5A50001);
    chk("both1_addr", act_addr, 32'h30);
    mem_data = 32'h0BADF00D;
    wait_done("both2", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("both2_lat", cyc, 32'd5);
    chk("both2_owner", {30'b0, gi, gd}, 32'b01);
    chk("both2_data", rd, 32'h0BADF00D);
    chk("both2_addr", act_addr, 32'h40);
    chk("both2_gap_ge2", {31'b0, last_gap >= 2}, 32'd1);
    after_done("both2");

    // Timeout: memory silent, TIMEOUT=8 -> ERR 8 cycles after REQ entry.
    mem_en = 1'b0; d_addr = 32'h50; d_req = 1'b1;
    wait_done("tmo", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("tmo_lat", cyc, 32'd9);
    chk("tmo_err", {31'b0, ge}, 32'd1);
    chk("tmo_owner", {30'b0, gi, gd}, 32'b01);
    chk("tmo_rdata", rd, 32'd0);
    chk("tmo_nrd", nrd, 32'd8);
    after_done("tmo");
    mem_en = 1'b1; mem_data = 32'h000055AA; d_addr = 32'h54; d_req = 1'b1;
    wait_done("post_tmo", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("post_tmo_lat", cyc, 32'd4);
    chk("post_tmo_err", {31'b0, ge}, 32'd0);
    chk("post_tmo_data", rd, 32'h000055AA);
    after_done("post_tmo");

    // Reset during REQ aborts without a done pulse.
    i_addr = 32'h60; i_req = 1'b1;
    @(negedge clk);
    chk("abort_in_req", {31'b0, mem_read}, 32'd1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
    chk("abort_no_done", {29'b0, i_done, d_done, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // First grant after reset goes to the instruction port on a tie.
    mem_data = 32'hCAFE0001; i_addr = 32'h64; d_addr = 32'h68; i_req = 1'b1; d_req = 1'b1;
    wait_done("rr1", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("rr1_owner", {30'b0, gi, gd}, 32'b10);
    chk("rr1_data", ri, 32'hCAFE0001);
    mem_data = 32'hCAFE0002;
    wait_done("rr2", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("rr2_owner", {30'b0, gi, gd}, 32'b01);
    chk("rr2_data", rd, 32'hCAFE0002);
    after_done("rr2");

    // Lone instruction grant hands prio to data; a following tie goes to data.
    i_req = 1'b1;
    wait_done("solo", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    after_done("solo");
    i_req = 1'b1; d_req = 1'b1;
    wait_done("tie_d", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("tie_d_owner", {30'b0, gi, gd}, 32'b01);
    wait_done("tie_i", 30, cyc, gi, gd, ge, ri, rd, nrd, nwr);
    chk("tie_i_owner", {30'b0, gi, gd}, 32'b10);
    after_done("tie_i");

    // Stray mem_resp in IDLE is ignored.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stray_done", {29'b0, i_done, d_done, err}, 32'd0);
    chk("stray_rw", {30'b0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    chk("stray_done2", {29'b0, i_done, d_done, err}, 32'd0);
    chk("stray_rw2", {30'b0, mem_read, mem_write}, 32'd0);

    chk("never_both", both_hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles spent waiting for mem_resp (legal range 2..2^16).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_req  input  1  instruction-port read request; held high until i_done.
REQ-007 i_addr  input  ADDR_WIDTH  instruction-port address; stable while i_req is high.
REQ-008 i_rdata  output  DATA_WIDTH  instruction read data; valid only while i_done=1.
REQ-009 i_done  output  1  one-cycle completion pulse for the instruction port.
REQ-010 d_req  input  1  data-port request; held high until d_done.
REQ-011 d_we  input  1  data-port direction: 1=write, 0=read; stable while d_req is high.
REQ-012 d_addr  input  ADDR_WIDTH  data-port address.
REQ-013 d_wdata  input  DATA_WIDTH  data-port write data.
REQ-014 d_rdata  output  DATA_WIDTH  data-port read data; valid only while d_done=1.
REQ-015 d_done  output  1  one-cycle completion pulse for the data port.
REQ-016 err  output  1  one-cycle pulse, coincident with i_done/d_done, flagging a timed-out access.
REQ-017 mem_read / mem_write  output  1 each  level requests to the memory; never both high.
REQ-018 mem_addr  output  ADDR_WIDTH;  mem_wdata  output  DATA_WIDTH;  both driven from registered copies.
REQ-019 mem_rdata  input  DATA_WIDTH  memory read data; valid the cycle after mem_resp.
REQ-020 mem_resp  input  1  one-cycle memory completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, REQ, DATA, DONE and ERR.
REQ-022 IDLE: if any request is pending, SHALL latch owner, addr, we and wdata, then go to REQ; otherwise stay in IDLE.
REQ-023 Arbitration: a single requester SHALL be granted; on simultaneous requests, the holder of the prio bit SHALL be granted; prio SHALL toggle to the other port after every grant.
REQ-024 The instruction port SHALL always perform reads; i_req SHALL force we=0.
REQ-025 REQ: mem_read (we=0) or mem_write (we=1) SHALL be high and mem_addr/mem_wdata stable; the state SHALL be held until mem_resp=1.
REQ-026 REQ on mem_resp: a read SHALL go to DATA; a write SHALL go to DONE.
REQ-027 DATA: mem_read low; mem_rdata SHALL be captured into the rdata register; next state DONE.
REQ-028 DONE: owner's done=1 for exactly one cycle and rdata driven (0 for writes); next state IDLE.
REQ-029 Timeout: a wait counter SHALL clear on entry to REQ and increment each REQ cycle; when it reaches TIMEOUT-1 without mem_resp, the FSM SHALL go to ERR.
REQ-030 ERR: owner's done=1 and err=1 for one cycle, rdata=0; next state IDLE.
REQ-031 mem_resp received outside REQ SHALL be ignored.
REQ-032 mem_read/mem_write SHALL be low in DATA, DONE, ERR and IDLE, guaranteeing at least 2 low cycles between accesses so the memory sees a fresh rising edge.
REQ-033 Requesters SHALL drop req the cycle after done; requests SHALL be sampled only in IDLE.
REQ-034 Read latency from grant SHALL be (memory wait) + 3 cycles: REQ ends on mem_resp, then DATA, then DONE.
REQ-035 Non-owner done SHALL remain 0; i_rdata/d_rdata SHALL be 0 whenever the matching done is 0.

Reset
REQ-036 While rst=1, the arbiter SHALL be in state IDLE and SHALL drive prio=instruction, mem_read=mem_write=0, mem_addr=mem_wdata=0, i_done=d_done=err=0, i_rdata=d_rdata=0, and counter=0.
REQ-037 Reset asserted mid-access SHALL abort the access with no done pulse; the first grant after reset SHALL follow REQ-023.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the FSM state enum, the owner enum (OWN_I, OWN_D) and the default TIMEOUT constant.
REQ-039 The design SHALL be a single module with no sub-modules; arbitration is a 1-bit toggle.

Verification
REQ-040 Scenario: i_req, i_addr=0x10, memory DELAY=2 returning 0xDEADBEEF -> i_done exactly once, i_rdata=0xDEADBEEF, mem_read high only in REQ.
REQ-041 Scenario: d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_write high with those values, mem_read stays 0, d_done with d_rdata=0.
REQ-042 Scenario: i_req and d_req both raised in the same cycle after reset -> instruction port served first, data port second, with mem_read low for ≥2 cycles between the two accesses.
REQ-043 Scenario: memory never responds, TIMEOUT=8 -> err and d_done pulse together 8 cycles after entry to REQ, d_rdata=0; the next request is served normally.
REQ-044 Scenario: rst asserted during REQ -> mem_read=0 and no done pulse on the next cycle; a fresh request after rst is released completes.
REQ-045 Scenario: stray mem_resp pulse in IDLE -> no done, no state change.
